// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states, opcodes,
// funct codes and ALU control values.
package mc_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        BRANCHNE = 4'd9,
        ADDIEX   = 4'd10,
        ADDIWB   = 4'd11,
        JUMP     = 4'd12
    } statetype;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mc_aludec.sv
// ALU decoder: maps the FSM's aluop and the R-type funct field to alucontrol.
module mc_aludec
    import mc_pkg::*;
(
    input  logic [5:0] funct,
    input  logic [1:0] aluop,
    output logic [2:0] alucontrol
);

    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alucontrol = ALU_ADD;
                    FN_SUB:  alucontrol = ALU_SUB;
                    FN_AND:  alucontrol = ALU_AND;
                    FN_OR:   alucontrol = ALU_OR;
                    FN_SLT:  alucontrol = ALU_SLT;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            // aluop 11 is reserved and falls back to add
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: Moore FSM sequencing each instruction, output
// decode per state, PC enable and the ALU decoder.
module mc_controller
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic       pcen,
    output logic [2:0] alucontrol
);

    statetype   state, state_nxt;
    logic       pcwrite, branch, bne;
    logic [1:0] aluop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= FETCH;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = FETCH;
        case (state)
            FETCH: state_nxt = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_nxt = MEMADR;
                    OP_RTYPE:     state_nxt = EXECUTE;
                    OP_BEQ:       state_nxt = BRANCH;
                    OP_BNE:       state_nxt = BRANCHNE;
                    OP_ADDI:      state_nxt = ADDIEX;
                    OP_J:         state_nxt = JUMP;
                    default:      state_nxt = FETCH;
                endcase
            end
            MEMADR:  state_nxt = (op == OP_SW) ? MEMWR : MEMRD;
            MEMRD:   state_nxt = MEMWB;
            EXECUTE: state_nxt = ALUWB;
            ADDIEX:  state_nxt = ADDIWB;
            default: state_nxt = FETCH;
        endcase
    end

    always_comb begin
        iord     = 1'b0;
        memwrite = 1'b0;
        irwrite  = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        regwrite = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        pcsrc    = 2'b00;
        pcwrite  = 1'b0;
        branch   = 1'b0;
        bne      = 1'b0;
        aluop    = ALUOP_ADD;
        case (state)
            FETCH: begin
                irwrite = 1'b1;
                pcwrite = 1'b1;
                alusrcb = 2'b01;
            end
            // branch target is precomputed into ALUOut here
            DECODE: alusrcb = 2'b11;
            MEMADR, ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            MEMRD: iord = 1'b1;
            MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            EXECUTE: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
            end
            ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            ADDIWB: regwrite = 1'b1;
            BRANCH, BRANCHNE: begin
                alusrca = 1'b1;
                aluop   = ALUOP_SUB;
                pcsrc   = 2'b01;
                branch  = (state == BRANCH);
                bne     = (state == BRANCHNE);
            end
            JUMP: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: ;
        endcase
    end

    // zero arrives combinationally from the ALU in the same cycle
    assign pcen = pcwrite | (branch & zero) | (bne & ~zero);

    mc_aludec u_aludec (
        .funct      (funct),
        .aluop      (aluop),
        .alucontrol (alucontrol)
    );

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Control unit for the multicycle MIPS datapath: register file, flops, muxes, sign-extend and shift-left-2 units.
- Moore FSM that sequences each instruction over 3–5 cycles, plus a combinational ALU decoder.
- Drives every mux select and enable in the datapath from the IR opcode/funct fields and the ALU zero flag.
- Supported instructions: lw, sw, R-type (add, sub, and, or, slt), beq, bne, addi, j.

Parameters:
- None. The block is fixed to MIPS-I 6-bit opcode/funct encodings.

Ports:
- clk  in  1  system clock, rising-edge
- reset  in  1  asynchronous, active-high; forces FETCH
- op  in  6  instruction opcode, instr[31:26], from the IR
- funct  in  6  R-type function field, instr[5:0]
- zero  in  1  ALU zero flag, combinational in the current cycle
- iord  out  1  memory address select: 0=PC, 1=ALUOut
- memwrite  out  1  data memory write enable
- irwrite  out  1  instruction register enable
- regdst  out  1  register write address select: 0=rt, 1=rd
- memtoreg  out  1  register write data select: 0=ALUOut, 1=Data
- regwrite  out  1  register file write enable (we3)
- alusrca  out  1  ALU A source: 0=PC, 1=A register
- alusrcb  out  2  ALU B source: 00=B, 01=4, 10=SignImm, 11=SignImm<<2
- pcsrc  out  2  PC source: 00=ALUResult, 01=ALUOut, 10=jump target
- pcen  out  1  PC flop enable
- alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt

Behaviour:
- One state register, asynchronously reset to FETCH. All outputs except pcen and alucontrol are decoded from the state only (Moore).
- Reset output values equal the FETCH outputs: irwrite=1, pcwrite=1, alusrcb=01, alusrca=0, iord=0, pcsrc=00, aluop=00. All other outputs are 0.
- pcen = pcwrite | (branch & zero) | (bne & ~zero). This term is combinational on zero.
- State transitions:
  - FETCH -> DECODE, unconditionally.
  - DECODE: lw/sw -> MEMADR; R-type -> EXECUTE; beq -> BRANCH; bne -> BRANCHNE; addi -> ADDIEX; j -> JUMP; any other opcode -> FETCH (executes as a no-op).
  - MEMADR: lw -> MEMRD; sw -> MEMWR.
  - MEMRD -> MEMWB -> FETCH.
  - MEMWR -> FETCH.
  - EXECUTE -> ALUWB -> FETCH.
  - ADDIEX -> ADDIWB -> FETCH.
  - BRANCH, BRANCHNE, JUMP -> FETCH.
- Per-state outputs (unlisted outputs are 0):
  - DECODE: alusrca=0, alusrcb=11, aluop=00 (branch target precomputed into ALUOut).
  - MEMADR, ADDIEX: alusrca=1, alusrcb=10, aluop=00.
  - MEMRD: iord=1.
  - MEMWB: regdst=0, memtoreg=1, regwrite=1.
  - MEMWR: iord=1, memwrite=1.
  - EXECUTE: alusrca=1, alusrcb=00, aluop=10.
  - ALUWB: regdst=1, memtoreg=0, regwrite=1.
  - ADDIWB: regdst=0, memtoreg=0, regwrite=1.
  - BRANCH / BRANCHNE: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1 / bne=1.
  - JUMP: pcsrc=10, pcwrite=1.
- ALU decoder:
  - aluop=00 -> add.
  - aluop=01 -> sub.
  - aluop=10 -> decode funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt; any other funct -> 010 (add).
  - aluop=11 is reserved -> 010.
- Cycles per instruction: lw 5; sw, R-type, addi 4; beq, bne, j 3.
- Reset asserted mid-instruction aborts it immediately. No regwrite or memwrite pulse may occur after reset assertion, and the next instruction starts at FETCH.
- op and funct are sampled only in DECODE and MEMADR/EXECUTE. The IR holds them stable because irwrite is asserted only in FETCH.
- No X on any output in any state. An unused state encoding returns to FETCH on the next clock.

Decomposition:
- Package mc_pkg:
  - statetype enum (4 bits, 13 states).
  - opcode localparams: OP_RTYPE=000000, OP_LW=100011, OP_SW=101011, OP_BEQ=000100, OP_BNE=000101, OP_ADDI=001000, OP_J=000010.
  - funct localparams.
  - aluop and alucontrol localparams.
- Sub-module mc_aludec: combinational, inputs funct[5:0] and aluop[1:0], output alucontrol[2:0].
- mc_controller holds the state register, next-state logic, output decode and pcen logic.

Test Plan:
- Reset held for 2 cycles, then released -> state=FETCH; irwrite=1, pcen=1, alusrcb=01; regwrite=0, memwrite=0.
- op=100011 (lw) -> 5-cycle sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB; iord=1 only in MEMRD; regwrite=1 with memtoreg=1 only in MEMWB.
- op=000000, funct=101010 (slt) -> alucontrol=111 in EXECUTE; regwrite=1 with regdst=1 in ALUWB; 4 cycles, then FETCH.
- op=000100 (beq) in BRANCH with zero=1 -> pcen=1, pcsrc=01. Same with zero=0 -> pcen=0. For bne the polarity is inverted.
- op=101011 (sw), then reset asserted during MEMADR -> memwrite never asserts; state=FETCH immediately.
- op=111111 (undefined) -> DECODE then FETCH; no regwrite or memwrite at any point.
